// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared encodings and sizing helper for the RV32 hazard controller
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_LU    = 2'd1;
    localparam logic [1:0] S_DMISS = 2'd2;

    // Width of the bubble counter: clog2(bubbles + 1), minimum 1.
    function automatic int bub_cnt_w(input int bubbles);
        int w;
        w = 1;
        while ((1 << w) < (bubbles + 1)) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_perf_cnt
//  Purpose  : Stall / redirect / D-miss event counters with synchronous clear
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall_inc,
    input  logic             i_redir_inc,
    input  logic             i_dmiss_inc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_redir_cnt,
    output logic [CNT_W-1:0] o_dmiss_cnt
);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redir_cnt;
    logic [CNT_W-1:0] r_dmiss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
            r_dmiss_cnt <= '0;
        end else begin
            if (i_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (i_redir_inc) r_redir_cnt <= r_redir_cnt + CNT_W'(1);
            if (i_dmiss_inc) r_dmiss_cnt <= r_dmiss_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_redir_cnt = r_redir_cnt;
    assign o_dmiss_cnt = r_dmiss_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_v2
//  Purpose  : 5-stage RV32 stall/flush/forward control with load-use FSM,
//             D-cache freeze and performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_v2
    import hazard_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int FORWARD_EN       = 1,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic              ICacheMiss,
    input  logic              DCacheMiss,
    input  logic              BranchE,
    input  logic              JalrE,
    input  logic              JalD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        RegReadD,
    input  logic [1:0]        RegReadE,
    input  logic [2:0]        MemToRegE,
    input  logic [2:0]        MemToRegM,
    input  logic [2:0]        RegWriteE,
    input  logic [2:0]        RegWriteM,
    input  logic [2:0]        RegWriteW,
    output logic              StallF,
    output logic              FlushF,
    output logic              StallD,
    output logic              FlushD,
    output logic              StallE,
    output logic              FlushE,
    output logic              StallM,
    output logic              FlushM,
    output logic              StallW,
    output logic              FlushW,
    output logic [1:0]        Forward1E,
    output logic [1:0]        Forward2E,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  RedirectCnt,
    output logic [CNT_W-1:0]  DMissCnt
);

    localparam int                 c_bub_w    = bub_cnt_w(LOAD_USE_BUBBLES);
    localparam logic [c_bub_w-1:0] c_bub_init = c_bub_w'(LOAD_USE_BUBBLES - 1);
    localparam logic [c_bub_w-1:0] c_bub_one  = c_bub_w'(1);

    function automatic logic hit(input logic [REG_AW-1:0] x,
                                 input logic [REG_AW-1:0] y,
                                 input logic [2:0]        wr);
        return (x == y) && (y != '0) && (wr != 3'd0);
    endfunction

    logic [1:0]         r_state;
    logic [c_bub_w-1:0] r_cnt;

    logic w_d_hit_e;
    logic w_d_hit_m;
    logic w_load_use;
    logic w_raw;
    logic w_redir;
    logic w_in_lu;

    assign w_d_hit_e = (RegReadD[1] && hit(Rs1D, RdE, RegWriteE)) ||
                       (RegReadD[0] && hit(Rs2D, RdE, RegWriteE));
    assign w_d_hit_m = (RegReadD[1] && hit(Rs1D, RdM, RegWriteM)) ||
                       (RegReadD[0] && hit(Rs2D, RdM, RegWriteM));

    // A load still in M is a hazard only when its data arrives more than a cycle late.
    assign w_load_use = ((MemToRegE != 3'd0) && w_d_hit_e) ||
                        ((LOAD_USE_BUBBLES >= 2) && (MemToRegM != 3'd0) && w_d_hit_m);
    assign w_raw      = (FORWARD_EN == 0) && (w_d_hit_e || w_d_hit_m);
    assign w_redir    = BranchE || JalrE;

    // Leaving DMISS with bubbles outstanding resumes the LU sequence in that same cycle.
    assign w_in_lu = (r_state == S_LU) || ((r_state == S_DMISS) && (r_cnt != '0));

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else if (DCacheMiss) begin
            r_state <= S_DMISS;
        end else if (w_redir) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else if (w_in_lu) begin
            r_cnt   <= r_cnt - c_bub_one;
            r_state <= (r_cnt == c_bub_one) ? S_RUN : S_LU;
        end else if (w_load_use && (LOAD_USE_BUBBLES > 1)) begin
            r_state <= S_LU;
            r_cnt   <= c_bub_init;
        end else begin
            r_state <= S_RUN;
        end
    end

    always_comb begin
        {StallF, FlushF, StallD, FlushD, StallE,
         FlushE, StallM, FlushM, StallW, FlushW} = 10'b0;
        if (CPU_RST) begin
            {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b11111;
        end else if (DCacheMiss) begin
            {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
        end else if (w_redir) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_load_use || w_in_lu || w_raw) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (ICacheMiss) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end else if (JalD) begin
            FlushD = 1'b1;
        end
    end

    always_comb begin
        Forward1E = FWD_RF;
        Forward2E = FWD_RF;
        if (!CPU_RST && (FORWARD_EN != 0)) begin
            if (RegReadE[1] && hit(Rs1E, RdM, RegWriteM))      Forward1E = FWD_M;
            else if (RegReadE[1] && hit(Rs1E, RdW, RegWriteW)) Forward1E = FWD_W;
            if (RegReadE[0] && hit(Rs2E, RdM, RegWriteM))      Forward2E = FWD_M;
            else if (RegReadE[0] && hit(Rs2E, RdW, RegWriteW)) Forward2E = FWD_W;
        end
    end

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (CPU_CLK),
        .rst         (CPU_RST),
        .i_stall_inc (StallF),
        .i_redir_inc (!DCacheMiss && (BranchE || JalrE || JalD)),
        .i_dmiss_inc (DCacheMiss),
        .o_stall_cnt (StallCnt),
        .o_redir_cnt (RedirectCnt),
        .o_dmiss_cnt (DMissCnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_v2
//  Purpose  : Directed self-checking bench; instance a forwards, instance b interlocks
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_v2;

    logic       clk;
    logic       rst;
    logic       icm, dcm, bre, jre, jd;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic [2:0] m2re, m2rm, rwe, rwm, rww;

    logic a_sf, a_ff, a_sd, a_fd, a_se, a_fe, a_sm, a_fm, a_sw, a_fw;
    logic b_sf, b_ff, b_sd, b_fd, b_se, b_fe, b_sm, b_fm, b_sw, b_fw;
    logic [1:0]  a_f1, a_f2, b_f1, b_f2;
    logic [31:0] a_scnt, a_rcnt, a_dcnt;
    logic [15:0] b_scnt, b_rcnt, b_dcnt;
    logic [9:0]  a_ctl, b_ctl;

    int n_chk  = 0;
    int n_pass = 0;

    // Control vector order: {SF,FF,SD,FD,SE,FE,SM,FM,SW,FW}
    localparam logic [9:0] CTL_NONE = 10'h000;
    localparam logic [9:0] CTL_RST  = 10'h155;
    localparam logic [9:0] CTL_LU   = 10'h290;
    localparam logic [9:0] CTL_DMS  = 10'h2A9;
    localparam logic [9:0] CTL_BR   = 10'h050;
    localparam logic [9:0] CTL_IC   = 10'h240;
    localparam logic [9:0] CTL_JAL  = 10'h040;

    assign a_ctl = {a_sf, a_ff, a_sd, a_fd, a_se, a_fe, a_sm, a_fm, a_sw, a_fw};
    assign b_ctl = {b_sf, b_ff, b_sd, b_fd, b_se, b_fe, b_sm, b_fm, b_sw, b_fw};

    hazard_ctrl_v2 #(.REG_AW(5), .FORWARD_EN(1), .LOAD_USE_BUBBLES(2), .CNT_W(32)) u_a (
        .CPU_CLK(clk), .CPU_RST(rst), .ICacheMiss(icm), .DCacheMiss(dcm),
        .BranchE(bre), .JalrE(jre), .JalD(jd),
        .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
        .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2re), .MemToRegM(m2rm),
        .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww),
        .StallF(a_sf), .FlushF(a_ff), .StallD(a_sd), .FlushD(a_fd), .StallE(a_se),
        .FlushE(a_fe), .StallM(a_sm), .FlushM(a_fm), .StallW(a_sw), .FlushW(a_fw),
        .Forward1E(a_f1), .Forward2E(a_f2),
        .StallCnt(a_scnt), .RedirectCnt(a_rcnt), .DMissCnt(a_dcnt)
    );

    hazard_ctrl_v2 #(.REG_AW(5), .FORWARD_EN(0), .LOAD_USE_BUBBLES(2), .CNT_W(16)) u_b (
        .CPU_CLK(clk), .CPU_RST(rst), .ICacheMiss(icm), .DCacheMiss(dcm),
        .BranchE(bre), .JalrE(jre), .JalD(jd),
        .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
        .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2re), .MemToRegM(m2rm),
        .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww),
        .StallF(b_sf), .FlushF(b_ff), .StallD(b_sd), .FlushD(b_fd), .StallE(b_se),
        .FlushE(b_fe), .StallM(b_sm), .FlushM(b_fm), .StallW(b_sw), .FlushW(b_fw),
        .Forward1E(b_f1), .Forward2E(b_f2),
        .StallCnt(b_scnt), .RedirectCnt(b_rcnt), .DMissCnt(b_dcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        {icm, dcm, bre, jre, jd} = '0;
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        {rrd, rre} = '0;
        {m2re, m2rm, rwe, rwm, rww} = '0;
    endtask

    // Load in E writing x7, consumer in D reads it through rs2.
    task automatic set_load_use();
        m2re = 3'd1; rde = 5'd7; rwe = 3'd1; rs2d = 5'd7; rrd = 2'b01;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        tick(); tick();
        #2;
        chk("rst_ctl", a_ctl, CTL_RST);
        chk("rst_fwd", {a_f1, a_f2}, 4'b0000);
        chk("rst_cnt", {a_scnt, a_rcnt, a_dcnt}, 96'd0);

        // Forwarding priority and the x0 exclusion
        rst = 1'b0;
        rdm = 5'd5; rwm = 3'd1; rs1e = 5'd5; rre = 2'b10;
        #1 chk("fwd1_m", a_f1, 2'b10);
        chk("run_ctl", a_ctl, CTL_NONE);
        rdw = 5'd5; rww = 3'd1;
        #1 chk("fwd1_m_over_w", a_f1, 2'b10);
        rs1e = 5'd0;
        #1 chk("fwd1_x0", a_f1, 2'b00);
        rs2e = 5'd5; rre = 2'b01;
        #1 chk("fwd2_m", a_f2, 2'b10);
        rdm = 5'd6;
        #1 chk("fwd2_w", a_f2, 2'b01);
        chk("fwd1_unused", a_f1, 2'b00);
        tick();

        // Load-use: two bubbles
        clr_in(); set_load_use();
        #2 chk("lu_detect", a_ctl, CTL_LU);
        tick();
        clr_in();
        #2 chk("lu_bubble2", a_ctl, CTL_LU);
        tick();
        #2 chk("lu_done", a_ctl, CTL_NONE);
        chk("lu_stallcnt", a_scnt, 32'd2);

        // D-cache miss while a bubble is outstanding
        set_load_use();
        #2 chk("lu2_detect", a_ctl, CTL_LU);
        tick();
        clr_in(); dcm = 1'b1;
        #2 chk("dmiss_c1", a_ctl, CTL_DMS);
        tick();
        #2 chk("dmiss_c2", a_ctl, CTL_DMS);
        tick();
        #2 chk("dmiss_c3", a_ctl, CTL_DMS);
        tick();
        dcm = 1'b0;
        #2 chk("dmiss_resume_bubble", a_ctl, CTL_LU);
        tick();
        #2 chk("dmiss_after", a_ctl, CTL_NONE);
        chk("dmiss_cnt", a_dcnt, 32'd3);
        chk("dmiss_stallcnt", a_scnt, 32'd7);

        // Branch during LU with an I-cache miss pending
        set_load_use();
        #2 chk("lu3_detect", a_ctl, CTL_LU);
        tick();
        clr_in(); bre = 1'b1; icm = 1'b1;
        #2 chk("br_in_lu", a_ctl, CTL_BR);
        chk("br_stallcnt", a_scnt, 32'd8);
        tick();
        bre = 1'b0;
        #2 chk("icmiss_after_br", a_ctl, CTL_IC);
        chk("br_redircnt", a_rcnt, 32'd1);
        tick();
        icm = 1'b0; jd = 1'b1;
        #2 chk("jald", a_ctl, CTL_JAL);
        tick();
        jd = 1'b0;
        #2 chk("jal_redircnt", a_rcnt, 32'd2);
        chk("ic_stallcnt", a_scnt, 32'd9);

        // Reset while frozen with a bubble pending
        set_load_use();
        #2 chk("lu4_detect", a_ctl, CTL_LU);
        tick();
        clr_in(); dcm = 1'b1;
        tick();
        rst = 1'b1;
        #2 chk("rst_in_dmiss", a_ctl, CTL_RST);
        tick();
        rst = 1'b0; dcm = 1'b0;
        #2 chk("rst_no_bubble", a_ctl, CTL_NONE);
        chk("rst_cnt_clear", {a_scnt, a_rcnt, a_dcnt}, 96'd0);

        // Interlock instance: RAW on M stalls, W does not, forwarding off
        clr_in();
        rdm = 5'd3; rwm = 3'd1; rs1d = 5'd3; rrd = 2'b10; rs1e = 5'd3; rre = 2'b10;
        #2 chk("il_raw_m", b_ctl, CTL_LU);
        chk("il_fwd_off", {b_f1, b_f2}, 4'b0000);
        chk("fe_fwd_on", a_f1, 2'b10);
        tick();
        rdm = 5'd0; rwm = 3'd0; rdw = 5'd3; rww = 3'd1;
        #2 chk("il_w_no_stall", b_ctl, CTL_NONE);
        chk("il_fwd_off_w", b_f1, 2'b00);
        chk("il_stallcnt", b_scnt, 16'd1);
        rde = 5'd3; rwe = 3'd1;
        #2 chk("il_raw_e", b_ctl, CTL_LU);
        tick();
        clr_in();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
